// File: rtl/ysyx_220066_defs.sv
// Shared definitions for the ysyx_220066 load/store unit.
// Contents:
//   MEMOP_*    RISC-V load/store funct3 encodings
//   ST_*       LSU control state encoding
//   size_mask  byte-strobe pattern for an access size, before lane shifting
//   misaligned true when an access does not sit on its natural boundary
package ysyx_220066_defs;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // size is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return offset[0];
      2'd2:    return |offset[1:0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220066_load_align.sv
// Load data alignment: selects the addressed byte lane out of an 8-byte
// read beat and sign- or zero-extends it to 64 bits according to funct3.
// Ports:
//   rdata   in  64  aligned 8-byte read beat from the bus
//   offset  in  3   byte offset of the access within the beat
//   memop   in  3   load funct3 (B/H/W/D/BU/HU/WU)
//   data    out 64  extended load result
module ysyx_220066_load_align
  import ysyx_220066_defs::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  memop,
  output logic [63:0] data
);

  logic [63:0] shifted;

  // Bring the addressed lane down to bit 0; the access never crosses the beat.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (memop)
      MEMOP_B:  data = {{56{shifted[7]}},  shifted[7:0]};
      MEMOP_H:  data = {{48{shifted[15]}}, shifted[15:0]};
      MEMOP_W:  data = {{32{shifted[31]}}, shifted[31:0]};
      MEMOP_D:  data = shifted;
      MEMOP_BU: data = {56'h0, shifted[7:0]};
      MEMOP_HU: data = {48'h0, shifted[15:0]};
      MEMOP_WU: data = {32'h0, shifted[31:0]};
      default:  data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_lsu.sv
// Load/store unit at the memory end of EX. Accepts one EX result per cycle
// when not blocked, passes non-memory results straight to the output
// register, rejects misaligned accesses with an error, and runs one bus
// transaction (request, then response) for each aligned load or store.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   valid_in .. rd_in         EX outputs (address/result, store data, funct3,
//                             MemRd/MemWr/RegWr, destination register)
//   flush                     kill incoming and output instruction
//   block_in / block_out      writeback back-pressure in / EX stall out
//   req_*                     bus request channel (valid/ready handshake)
//   resp_*                    bus response channel (valid only)
//   valid_out .. result_out   registered writeback result
module ysyx_220066_lsu
  import ysyx_220066_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  input  logic [2:0]  MemOp_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        RegWr_in,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic        block_in,
  output logic        block_out,
  output logic        req_valid,
  output logic        req_wen,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wmask,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [63:0] resp_rdata,
  input  logic        resp_err,
  output logic        valid_out,
  output logic        error_out,
  output logic        RegWr_out,
  output logic [4:0]  rd_out,
  output logic [63:0] result_out
);

  logic [1:0]  state;
  logic [63:0] addr_p1;
  logic [63:0] wdata_p1;
  logic [2:0]  memop_p1;
  logic        wen_p1;
  logic        regwr_p1;
  logic [4:0]  rd_p1;
  logic        drop_p1;
  logic [63:0] load_data;

  logic hold;
  logic accept;
  logic is_mem;
  logic mis;
  logic done;

  assign hold      = valid_out & block_in;
  assign block_out = (state != ST_IDLE) | hold;
  assign accept    = valid_in & ~flush & ~block_out;
  assign is_mem    = MemRd_in | MemWr_in;
  assign mis       = misaligned(MemOp_in[1:0], addr_in[2:0]);
  assign done      = (state == ST_RESP) & resp_valid;

  // Request channel is driven straight from the latched op, so it stays
  // stable for as long as the bus withholds req_ready.
  assign req_valid = (state == ST_REQ);
  assign req_wen   = req_valid & wen_p1;
  assign req_addr  = {addr_p1[63:3], 3'b000};
  assign req_wdata = wdata_p1 << {addr_p1[2:0], 3'b000};
  assign req_wmask = req_wen ? (size_mask(memop_p1[1:0]) << addr_p1[2:0]) : 8'h00;

  ysyx_220066_load_align u_load_align (
    .rdata  (resp_rdata),
    .offset (addr_p1[2:0]),
    .memop  (memop_p1),
    .data   (load_data)
  );

  // ---- p0 -> p1: latch the accepted EX op ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= addr_in;
      wdata_p1 <= wdata_in;
      memop_p1 <= MemOp_in;
      wen_p1   <= MemWr_in;
      regwr_p1 <= RegWr_in;
      rd_p1    <= rd_in;
    end
  end

  // A flushed transaction keeps running on the bus; drop_p1 only suppresses
  // its writeback when the response arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      drop_p1 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept && is_mem && !mis) begin
          state   <= ST_REQ;
          drop_p1 <= 1'b0;
        end
        ST_REQ:  if (req_ready)  state <= ST_RESP;
        ST_RESP: if (resp_valid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (flush && state != ST_IDLE) drop_p1 <= 1'b1;
    end
  end

  // ---- p1 -> p2: writeback output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      error_out  <= 1'b0;
      RegWr_out  <= 1'b0;
      rd_out     <= 5'd0;
      result_out <= 64'd0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (!hold) begin
      if (accept && !is_mem) begin
        valid_out  <= 1'b1;
        error_out  <= 1'b0;
        RegWr_out  <= RegWr_in;
        rd_out     <= rd_in;
        result_out <= addr_in;
      end else if (accept && mis) begin
        // Faulting address is reported as the result for the trap handler.
        valid_out  <= 1'b1;
        error_out  <= 1'b1;
        RegWr_out  <= 1'b0;
        rd_out     <= rd_in;
        result_out <= addr_in;
      end else if (done && !drop_p1) begin
        valid_out  <= 1'b1;
        error_out  <= resp_err;
        RegWr_out  <= regwr_p1 & ~wen_p1 & ~resp_err;
        rd_out     <= rd_p1;
        result_out <= wen_p1 ? addr_p1 : load_data;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && state == ST_REQ) begin
      assert (!resp_valid) else $error("resp_valid asserted before request was accepted");
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
module tb_ysyx_220066_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [63:0] addr_in;
  logic [63:0] wdata_in;
  logic [2:0]  MemOp_in;
  logic        MemRd_in;
  logic        MemWr_in;
  logic        RegWr_in;
  logic [4:0]  rd_in;
  logic        flush;
  logic        block_in;
  logic        block_out;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        valid_out;
  logic        error_out;
  logic        RegWr_out;
  logic [4:0]  rd_out;
  logic [63:0] result_out;

  always #5 clk = ~clk;

  ysyx_220066_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .MemOp_in   (MemOp_in),
    .MemRd_in   (MemRd_in),
    .MemWr_in   (MemWr_in),
    .RegWr_in   (RegWr_in),
    .rd_in      (rd_in),
    .flush      (flush),
    .block_in   (block_in),
    .block_out  (block_out),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .RegWr_out  (RegWr_out),
    .rd_out     (rd_out),
    .result_out (result_out)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  memop;
    logic        rd_en;
    logic        wr_en;
    logic        regwr;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        err;
    logic        bus;
    logic [63:0] res;
    logic        chk_res;
    logic        exp_err;
    logic        exp_regwr;
    logic [7:0]  wmask;
    logic [63:0] bwdata;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        chk_res;
    logic        err;
    logic        regwr;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    chk1({name, "_valid"}, valid_out, 1'b1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got result %h want none", name, result_out);
    end else begin
      e = sb.pop_front();
      if (e.chk_res) chk64({name, "_result"}, result_out, e.res);
      chk1({name, "_err"}, error_out, e.err);
      chk1({name, "_regwr"}, RegWr_out, e.regwr);
      chk64({name, "_rd"}, {59'h0, rd_out}, {59'h0, e.rd});
    end
  endtask

  task automatic drive_op(input logic [63:0] a, input logic [63:0] wd, input logic [2:0] op,
                          input logic mr, input logic mw, input logic rw, input logic [4:0] rd);
    valid_in = 1'b1;
    addr_in  = a;
    wdata_in = wd;
    MemOp_in = op;
    MemRd_in = mr;
    MemWr_in = mw;
    RegWr_in = rw;
    rd_in    = rd;
  endtask

  task automatic push_exp(input logic [63:0] res, input logic cr, input logic err,
                          input logic rw, input logic [4:0] rd);
    exp_t e;
    e.res = res; e.chk_res = cr; e.err = err; e.regwr = rw; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    chk1({name, "_idle_block"}, block_out, 1'b0);
    drive_op(v.addr, v.wdata, v.memop, v.rd_en, v.wr_en, v.regwr, v.rd);
    push_exp(v.res, v.chk_res, v.exp_err, v.exp_regwr, v.rd);
    tick;
    valid_in = 1'b0;
    if (!v.bus) begin
      chk1({name, "_noreq"}, req_valid, 1'b0);
      pop_check(name);
    end else begin
      chk1({name, "_req"}, req_valid, 1'b1);
      chk64({name, "_raddr"}, req_addr, {v.addr[63:3], 3'b000});
      chk1({name, "_wen"}, req_wen, v.wr_en);
      if (v.wr_en) begin
        chk64({name, "_wmask"}, {56'h0, req_wmask}, {56'h0, v.wmask});
        chk64({name, "_wdata"}, req_wdata, v.bwdata);
      end
      chk1({name, "_stall"}, block_out, 1'b1);
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
      chk1({name, "_early"}, valid_out, 1'b0);
      resp_valid = 1'b1;
      resp_rdata = v.rdata;
      resp_err   = v.err;
      tick;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      pop_check(name);
    end
    tick;
    chk1({name, "_clear"}, valid_out, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached got running want finished");
    $fatal(1);
  end

  initial begin
    // addr, wdata, memop, rd_en, wr_en, regwr, rd, rdata, err, bus, res, chk_res, exp_err, exp_regwr, wmask, bwdata
    vecs[0]  = '{64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 64'h0, 1'b0, 1'b0, 64'h1234, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[1]  = '{64'h80000003, 64'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd6, 64'h0000000080000000, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[2]  = '{64'h80000003, 64'h0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd7, 64'h0000000080000000, 1'b0, 1'b1, 64'h80, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[3]  = '{64'h80000006, 64'hBEEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h80000006, 1'b1, 1'b0, 1'b0, 8'hC0, 64'hBEEF000000000000};
    vecs[4]  = '{64'h80000002, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd8, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[5]  = '{64'h80000008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd9, 64'h0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[6]  = '{64'h80000002, 64'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd10, 64'h0000000080010000, 1'b0, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[7]  = '{64'h80000004, 64'h0, 3'b110, 1'b1, 1'b0, 1'b1, 5'd11, 64'hDEADBEEF00000000, 1'b0, 1'b1, 64'h00000000DEADBEEF, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[8]  = '{64'h80000004, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd12, 64'hDEADBEEF00000000, 1'b0, 1'b1, 64'hFFFFFFFFDEADBEEF, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[9]  = '{64'h80000010, 64'h1122334455667788, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h80000010, 1'b1, 1'b0, 1'b0, 8'hFF, 64'h1122334455667788};
    vecs[10] = '{64'h80000005, 64'hAB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h80000005, 1'b1, 1'b0, 1'b0, 8'h20, 64'h0000AB0000000000};
    vecs[11] = '{64'h80000008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd13, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[12] = '{64'h8000000C, 64'hCAFEBABE, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h8000000C, 1'b1, 1'b0, 1'b0, 8'hF0, 64'hCAFEBABE00000000};
    vecs[13] = '{64'h80000004, 64'h55, 3'b011, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[14] = '{64'h80000006, 64'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd14, 64'h8001000000000000, 1'b0, 1'b1, 64'h8001, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[15] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd31, 64'h0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0};

    rst = 1'b0;
    valid_in = 1'b0; addr_in = '0; wdata_in = '0; MemOp_in = '0;
    MemRd_in = 1'b0; MemWr_in = 1'b0; RegWr_in = 1'b0; rd_in = '0;
    flush = 1'b0; block_in = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_err = 1'b0;

    repeat (2) tick;
    chk1("rst_valid", valid_out, 1'b0);
    chk1("rst_err", error_out, 1'b0);
    chk1("rst_regwr", RegWr_out, 1'b0);
    chk1("rst_req", req_valid, 1'b0);
    chk1("rst_wen", req_wen, 1'b0);
    chk64("rst_wmask", {56'h0, req_wmask}, 64'h0);
    chk64("rst_rd", {59'h0, rd_out}, 64'h0);
    chk64("rst_result", result_out, 64'h0);
    chk1("rst_block", block_out, 1'b0);
    rst = 1'b1;
    tick;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Request stalled by the bus for four cycles.
    drive_op(64'h80000020, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd3);
    push_exp(64'h000000007FFFFFFF, 1'b1, 1'b0, 1'b1, 5'd3);
    tick;
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("stall%0d_req", i), req_valid, 1'b1);
      chk64($sformatf("stall%0d_addr", i), req_addr, 64'h80000020);
      chk1($sformatf("stall%0d_block", i), block_out, 1'b1);
      chk1($sformatf("stall%0d_vout", i), valid_out, 1'b0);
      tick;
    end
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    chk1("stall_resp_block", block_out, 1'b1);
    chk1("stall_resp_vout", valid_out, 1'b0);
    resp_valid = 1'b1;
    resp_rdata = 64'h000000007FFFFFFF;
    tick;
    resp_valid = 1'b0;
    pop_check("stall");
    tick;

    // Flush while waiting for the response: bus completes, nothing written back.
    drive_op(64'h80000040, 64'h0, 3'b011, 1'b1, 1'b0, 1'b1, 5'd4);
    tick;
    valid_in = 1'b0;
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk1("flush_vout0", valid_out, 1'b0);
    chk1("flush_block", block_out, 1'b1);
    resp_valid = 1'b1;
    resp_rdata = 64'h5555AAAA5555AAAA;
    tick;
    resp_valid = 1'b0;
    chk1("flush_vout1", valid_out, 1'b0);
    chk1("flush_idle", block_out, 1'b0);
    tick;
    chk1("flush_vout2", valid_out, 1'b0);

    // Flush discards the op presented in the same cycle.
    drive_op(64'h7777, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    valid_in = 1'b0;
    chk1("flush_in_vout", valid_out, 1'b0);
    tick;

    // Writeback back-pressure holds the output and stalls the next op.
    drive_op(64'hAAAA, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd1);
    push_exp(64'hAAAA, 1'b1, 1'b0, 1'b1, 5'd1);
    tick;
    pop_check("blkA");
    block_in = 1'b1;
    drive_op(64'hBBBB, 64'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd2);
    #1;
    chk1("blk_block0", block_out, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk1($sformatf("blk%0d_vout", i), valid_out, 1'b1);
      chk64($sformatf("blk%0d_res", i), result_out, 64'hAAAA);
      chk64($sformatf("blk%0d_rd", i), {59'h0, rd_out}, 64'd1);
      chk1($sformatf("blk%0d_block", i), block_out, 1'b1);
    end
    block_in = 1'b0;
    #1;
    chk1("blk_release", block_out, 1'b0);
    push_exp(64'hBBBB, 1'b1, 1'b0, 1'b1, 5'd2);
    tick;
    valid_in = 1'b0;
    pop_check("blkB");
    tick;
    chk1("blk_clear", valid_out, 1'b0);

    // Reset in the middle of a request returns to idle at once.
    drive_op(64'h80000080, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd15);
    tick;
    valid_in = 1'b0;
    chk1("mrst_req_before", req_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mrst_req", req_valid, 1'b0);
    chk1("mrst_block", block_out, 1'b0);
    chk1("mrst_vout", valid_out, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    run_vec(vecs[0], "post_rst");

    chk64("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
